// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into LANES-wide words on a registered
// valid/ready output. A flush closes out a partial word with a keep mask.
module byte_word_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         u2d_data_i,
  input  logic                      u2d_valid_i,
  output logic                      u2d_ready_o,
  input  logic                      flush_i,
  output logic [LANES*DATA_W-1:0]   d2u_data_o,
  output logic [LANES-1:0]          d2u_keep_o,
  output logic                      d2u_valid_o,
  input  logic                      d2u_ready_i
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int N_W   = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

  logic [DATA_W-1:0]       acc_q [LANES];
  logic [DATA_W-1:0]       acc_d [LANES];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0]        keep_q, keep_d;
  logic                    valid_q, valid_d;

  logic                    slot_free;
  logic                    last;
  logic                    ready;
  logic                    accept;
  logic                    flush_go;
  logic                    emit;
  logic [N_W-1:0]          n_fill;
  logic [LANES*DATA_W-1:0] word_data;
  logic [LANES-1:0]        word_keep;

  assign slot_free = !valid_q || d2u_ready_i;
  assign last      = (cnt_q == LAST_CNT);
  // Only a word-producing action needs the output slot; lower lanes keep filling.
  assign ready     = rst_n && (slot_free || (!last && !flush_i));
  assign accept    = u2d_valid_i && ready;
  assign flush_go  = flush_i && ready;
  assign n_fill    = N_W'(cnt_q) + N_W'(accept);
  assign emit      = (accept && last) || (flush_go && (n_fill != '0));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic              hit;
      logic [DATA_W-1:0] lane_val;

      assign hit       = accept && (cnt_q == CNT_W'(gi));
      assign lane_val  = hit ? u2d_data_i : acc_q[gi];
      assign word_keep[gi] = (N_W'(gi) < n_fill);
      assign word_data[gi*DATA_W +: DATA_W] = word_keep[gi] ? lane_val : '0;
      assign acc_d[gi] = emit ? '0 : lane_val;
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (emit) begin
      cnt_d   = '0;
      data_d  = word_data;
      keep_d  = word_keep;
      valid_d = 1'b1;
    end else begin
      if (accept) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (valid_q && d2u_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
      end
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign u2d_ready_o = ready;
  assign d2u_data_o  = data_q;
  assign d2u_keep_o  = keep_q;
  assign d2u_valid_o = valid_q;

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Downstream neighbour of the `ms` valid/ready pipeline stage. It consumes the 8-bit byte stream leaving the last `ms` stage and packs consecutive bytes, little-endian, into 32-bit words on a registered valid/ready output. A flush request closes out a partial word and emits it with a byte-keep mask. Sustained throughput is one byte per cycle when the downstream side is ready.

## Interface
- `DATA_W`, default 8: input lane width in bits.
- `LANES`, default 4: lanes per output word. Output width is `LANES*DATA_W`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `u2d_data_i`  in  DATA_W  input byte.
- `u2d_valid_i`  in  1  input byte valid.
- `u2d_ready_o`  out  1  block can accept a byte or a flush this cycle.
- `flush_i`  in  1  flush request. Hold high until a cycle where `u2d_ready_o=1`.
- `d2u_data_o`  out  LANES*DATA_W  packed word; lane 0 is bits [7:0].
- `d2u_keep_o`  out  LANES  keep mask; bit k set means lane k is valid.
- `d2u_valid_o`  out  1  output word valid.
- `d2u_ready_i`  in  1  downstream accepts the word.

## Operation
- State: accumulator `acc` (LANES lanes), byte count `cnt` (0..LANES-1), output register (`d2u_data_o`, `d2u_keep_o`, `d2u_valid_o`).
- `slot_free = !d2u_valid_o || d2u_ready_i`.
- `last = (cnt == LANES-1)`.
- `u2d_ready_o = rst_n && (slot_free || (!last && !flush_i))`. This is a combinational path from `d2u_ready_i`.
- Byte accept = `u2d_valid_i && u2d_ready_o`:
  - the byte is written to lane `cnt`;
  - if not `last`, `cnt` increments.
- Word completion: a byte accepted when `last`, with no flush:
  - `{byte, acc[LANES-2:0]}` is loaded into the output register;
  - `d2u_keep_o` = all ones;
  - `cnt` = 0.
- Flush completes when `flush_i && u2d_ready_o`. Let n = `cnt` plus 1 if a byte is accepted in the same cycle.
  - If n>0: emit the partial word, with lanes ≥ n zeroed and `d2u_keep_o` = (1<<n)-1. Then `cnt` = 0 and `acc` is cleared.
  - If n=0: no output; flush is a no-op.
  - If n=LANES: identical to a normal word completion.
- Output register: cleared to valid=0 on `d2u_valid_o && d2u_ready_i` unless reloaded in the same cycle. Data and keep hold while valid and not ready.
- Unused lanes of any emitted word are 0.
- `u2d_data_i` is ignored when the byte is not accepted.

## Timing
- Reset (async assert, sync-safe deassert):
  - `d2u_valid_o`=0, `d2u_data_o`=0, `d2u_keep_o`=0;
  - `cnt`=0, `acc`=0;
  - `u2d_ready_o`=0 while `rst_n` low.
- Reset mid-operation discards the partial accumulator and any pending word immediately.
- Latency: the word-completing byte accepted at edge N gives `d2u_valid_o`=1 from edge N until the handshake.
- Simultaneous output drain and word completion in one cycle: the new word loads; `d2u_valid_o` stays 1 with no bubble.
- Backpressure:
  - with `d2u_valid_o=1` and `d2u_ready_i=0`, bytes for lanes 0..LANES-2 are still accepted;
  - the completing byte and any flush stall (`u2d_ready_o`=0) until `d2u_ready_i`=1.
- `d2u_valid_o` never drops without a handshake. `d2u_data_o`/`d2u_keep_o` are stable while valid and not ready.
- Full throughput: with `d2u_ready_i`=1 constantly, `u2d_ready_o` stays 1 and one word issues every LANES accepted bytes.

## Test plan
- Reset, then stream bytes 0x00..0x0F back-to-back with `d2u_ready_i`=1:
  - words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each keep 0xF;
  - `u2d_ready_o` never low after reset.
- Hold `d2u_ready_i`=0 and send 0x10..0x17:
  - 0x13121110 is presented and held stable;
  - 0x14..0x16 are accepted and 0x17 stalls;
  - raising `d2u_ready_i` gives 0x13121110, then 0x17161514.
- Send 0x20, 0x21, 0x22, then assert `flush_i` alone:
  - word 0x00222120 with keep 0x7;
  - next bytes start at lane 0.
- Flush edge cases:
  - send 0x30, then 0x31 with `flush_i` in the same cycle → 0x00003130, keep 0x3;
  - immediately flush again with `cnt`=0 → no output word.
- Flush while the output is stalled (`d2u_ready_i`=0, word pending, 2 bytes in `acc`):
  - `u2d_ready_o`=0 until ready rises;
  - then the pending word drains and the partial word follows with keep 0x3.
- Reset mid-operation (2 bytes accumulated, word pending), then send 0x40..0x43:
  - `d2u_valid_o` drops at reset assertion;
  - the only output after reset is 0x43424140, keep 0xF.
